// File: rtl/zxw_cpu_defs.sv
// Definitions shared by the 4-bit CPU core and its input conditioning stage.
// Latency: none (types and constants only).
// Backpressure: none.
package zxw_cpu_defs;

  // Per-channel debounce FSM states (stable low, qualifying high, stable high, qualifying low)
  typedef enum logic [1:0] {
    S_LO      = 2'b00,
    S_LO_WAIT = 2'b01,
    S_HI      = 2'b10,
    S_HI_WAIT = 2'b11
  } db_state_t;

  // Memory-mapped I/O addresses seen by the core
  localparam logic [7:0] FC = 8'hFC;  // pushbutton levels
  localparam logic [7:0] FD = 8'hFD;  // slide switch levels
  localparam logic [7:0] FE = 8'hFE;
  localparam logic [7:0] FF = 8'hFF;

  localparam int NUM_SW = 4;
  localparam int NUM_PB = 4;

endpackage

// File: rtl/zxw_input_cond_v_if.sv
// Raw board inputs and conditioned outputs of the input stage.
// Latency: none (wires only).
// Backpressure: none; levels and strobes are sampled by the consumer every cycle.
interface zxw_input_cond_v_if;

  logic [3:0] SW_raw_pin;
  logic [3:0] PB_raw_pin;
  logic [3:0] SW_out;
  logic [3:0] PB_out;
  logic [3:0] PB_press;

  // Board / stimulus side: drives raw inputs, observes conditioned outputs
  modport master (
    output SW_raw_pin,
    output PB_raw_pin,
    input  SW_out,
    input  PB_out,
    input  PB_press
  );

  // Conditioning stage side
  modport slave (
    input  SW_raw_pin,
    input  PB_raw_pin,
    output SW_out,
    output PB_out,
    output PB_press
  );

endinterface

// File: rtl/zxw_debounce_v.sv
// One input channel: N-flop synchroniser followed by a four-state debounce FSM.
// Latency: q follows a clean change SYNC_STAGES+DB_CYCLES-1 edges after it is first sampled.
// Backpressure: none; rise_pulse is a single-cycle strobe with no acknowledge.
module zxw_debounce_v
  import zxw_cpu_defs::*;
#(
  parameter int DB_CYCLES   = 50000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock_pin,
  input  logic Reset_pin,
  input  logic level,
  output logic q,
  output logic rise_pulse
);

  // The sample that moves the FSM into a WAIT state is the first of the
  // DB_CYCLES stable samples, so the counter only has to cover the rest.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 2);

  generate
    if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W)) begin : g_bad_db
      $error("zxw_debounce_v: DB_CYCLES must lie in 2 .. 2**CNT_W");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("zxw_debounce_v: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   s;
  db_state_t              state;
  logic [CNT_W-1:0]       cnt;

  assign s = sync_ff[SYNC_STAGES-1];

  // Shift the asynchronous level through the synchroniser chain
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) sync_ff <= '0;
    else           sync_ff <= {sync_ff[SYNC_STAGES-2:0], level};
  end

  // Debounce FSM: a new level is accepted only after an unbroken run of samples
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) begin
      state      <= S_LO;
      cnt        <= '0;
      q          <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      case (state)
        S_LO: begin
          if (s) begin
            state <= S_LO_WAIT;
            cnt   <= '0;
          end
        end
        S_LO_WAIT: begin
          if (!s) begin
            state <= S_LO;
          end else if (cnt == DB_LAST) begin
            state      <= S_HI;
            q          <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HI: begin
          if (!s) begin
            state <= S_HI_WAIT;
            cnt   <= '0;
          end
        end
        S_HI_WAIT: begin
          if (s) begin
            state <= S_HI;
          end else if (cnt == DB_LAST) begin
            state <= S_LO;
            q     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_LO;
      endcase
    end
  end

endmodule

// File: rtl/zxw_input_cond_v.sv
// Input stage for the 4-bit core: sync + debounce of 4 switches and 4 buttons, press strobes.
// Latency: SYNC_STAGES+DB_CYCLES-1 edges from a clean raw change to SW_out/PB_out/PB_press.
// Backpressure: none; ZXW_INPUT_COND_PB_TOGGLE_EN turns PB_out into per-button toggle flags.
module zxw_input_cond_v
  import zxw_cpu_defs::*;
#(
  parameter int DB_CYCLES     = 50000,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter bit PB_ACTIVE_LOW = 1'b1
) (
  input  logic                Clock_pin,
  input  logic                Reset_pin,
  zxw_input_cond_v_if.slave   io
);

  localparam int NCH = NUM_SW + NUM_PB;

  logic [NUM_PB-1:0] pb_level;
  logic [NCH-1:0]    level;
  logic [NCH-1:0]    q;
  logic [NCH-1:0]    rise;
  logic [NUM_SW-1:0] unused_sw_rise;

  // Buttons are made active-high before synchronising so reset means "released"
  assign pb_level = PB_ACTIVE_LOW ? ~io.PB_raw_pin : io.PB_raw_pin;
  assign level    = {pb_level, io.SW_raw_pin};

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    zxw_debounce_v #(
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_db (
      .Clock_pin  (Clock_pin),
      .Reset_pin  (Reset_pin),
      .level      (level[i]),
      .q          (q[i]),
      .rise_pulse (rise[i])
    );
  end

  assign io.SW_out   = q[NUM_SW-1:0];
  assign io.PB_press = rise[NCH-1:NUM_SW];
  // Switches have no event interface; their strobes are deliberately dropped
  assign unused_sw_rise = rise[NUM_SW-1:0];

`ifdef ZXW_INPUT_COND_PB_TOGGLE_EN
  logic [NUM_PB-1:0] pb_toggle;

  // Accumulate presses; the XOR below shows the new value in the strobe cycle itself
  always_ff @(posedge Clock_pin) begin
    if (Reset_pin) pb_toggle <= '0;
    else           pb_toggle <= pb_toggle ^ rise[NCH-1:NUM_SW];
  end

  assign io.PB_out = pb_toggle ^ rise[NCH-1:NUM_SW];
`else
  assign io.PB_out = q[NCH-1:NUM_SW];
`endif

endmodule

// File: tb/tb_zxw_input_cond_v.sv
// Bench for zxw_input_cond_v: directed test-plan sequences plus randomized bouncing inputs,
// all checked every cycle against a run-length behavioural model, with literal spot checks.
module tb_zxw_input_cond_v;

  localparam int DB   = 4;
  localparam int SYNC = 2;
`ifdef ZXW_INPUT_COND_PB_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic Clock_pin = 1'b0;
  logic Reset_pin;
  zxw_input_cond_v_if bus ();

  zxw_input_cond_v #(
    .DB_CYCLES     (DB),
    .CNT_W         (16),
    .SYNC_STAGES   (SYNC),
    .PB_ACTIVE_LOW (1'b1)
  ) dut (
    .Clock_pin (Clock_pin),
    .Reset_pin (Reset_pin),
    .io        (bus.slave)
  );

  always #5 Clock_pin = ~Clock_pin;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // ---------------- behavioural model ----------------
  // Each channel: the FSM sees the raw (active-high) value from SYNC edges ago.
  // The stable level flips once DB consecutive samples disagree with it.
  bit         dl [8][SYNC];
  int         run [8];
  logic [7:0] mq = '0;
  logic [7:0] mp = '0;
  logic [7:0] mt = '0;
  bit         s_m;
  logic [7:0] raw_m;

  always @(posedge Clock_pin) begin
    raw_m = {~bus.PB_raw_pin, bus.SW_raw_pin};
    for (int c = 0; c < 8; c++) begin
      if (Reset_pin) begin
        for (int j = 0; j < SYNC; j++) dl[c][j] = 1'b0;
        run[c] = 0;
        mq[c]  = 1'b0;
        mp[c]  = 1'b0;
        mt[c]  = 1'b0;
      end else begin
        s_m = dl[c][SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) dl[c][j] = dl[c][j-1];
        dl[c][0] = raw_m[c];
        mp[c] = 1'b0;
        if (s_m != mq[c]) begin
          run[c]++;
          if (run[c] == DB) begin
            mq[c]  = s_m;
            run[c] = 0;
            if (s_m) begin
              mp[c] = 1'b1;
              mt[c] = ~mt[c];
            end
          end
        end else begin
          run[c] = 0;
        end
      end
    end
  end

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge Clock_pin) begin
    if (cmp_en) begin
      check4("model SW_out", bus.SW_out, mq[3:0]);
      check4("model PB_out", bus.PB_out, TOG ? mt[7:4] : mq[7:4]);
      check4("model PB_press", bus.PB_press, mp[7:4]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock_pin);
  endtask

  task automatic do_reset();
    Reset_pin = 1'b1;
    tick(2);
    Reset_pin = 1'b0;
    tick(2);
  endtask

  int         strobes;
  int         hold [8];
  logic [7:0] rv;
  int         rst_left;

  initial begin
    Reset_pin      = 1'b1;
    bus.PB_raw_pin = 4'b0000;
    bus.SW_raw_pin = 4'b0000;
    tick(1);
    cmp_en = 1'b1;

    // 1: reset with all buttons held pressed
    for (int n = 0; n < 3; n++) begin
      tick(1);
      check4("rst PB_out", bus.PB_out, 4'b0000);
      check4("rst PB_press", bus.PB_press, 4'b0000);
      check4("rst SW_out", bus.SW_out, 4'b0000);
    end
    Reset_pin = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      check4("post-rst PB_out early", bus.PB_out, 4'b0000);
    end
    tick(1);
    check4("post-rst PB_out", bus.PB_out, 4'b1111);
    check4("post-rst PB_press", bus.PB_press, 4'b1111);
    tick(1);
    check4("post-rst PB_press clear", bus.PB_press, 4'b0000);
    check4("post-rst PB_out hold", bus.PB_out, 4'b1111);
    bus.PB_raw_pin = 4'b1111;
    tick(8);
    check4("release PB_out", bus.PB_out, TOG ? 4'b1111 : 4'b0000);
    do_reset();

    // 2: clean press of button 0
    bus.PB_raw_pin = 4'b1110;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      check4("press PB_out early", bus.PB_out, 4'b0000);
      check4("press PB_press early", bus.PB_press, 4'b0000);
    end
    tick(1);
    check4("press PB_out", bus.PB_out, 4'b0001);
    check4("press PB_press", bus.PB_press, 4'b0001);
    tick(1);
    check4("press PB_press clear", bus.PB_press, 4'b0000);
    bus.PB_raw_pin = 4'b1111;
    tick(8);
    do_reset();

    // 3: bouncing button 1, then settled pressed
    strobes = 0;
    for (int seg = 0; seg < 6; seg++) begin
      bus.PB_raw_pin[1] = (seg % 2 == 1);
      for (int n = 0; n < 2; n++) begin
        tick(1);
        check4("bounce PB_out", {3'b000, bus.PB_out[1]}, 4'b0000);
        check4("bounce PB_press", bus.PB_press, 4'b0000);
      end
    end
    bus.PB_raw_pin[1] = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      check4("settle PB_out early", {3'b000, bus.PB_out[1]}, 4'b0000);
      if (bus.PB_press[1]) strobes++;
    end
    tick(1);
    check4("settle PB_out", {3'b000, bus.PB_out[1]}, 4'b0001);
    if (bus.PB_press[1]) strobes++;
    for (int n = 0; n < 6; n++) begin
      tick(1);
      if (bus.PB_press[1]) strobes++;
    end
    check4("bounce strobe count", 4'(strobes), 4'd1);
    bus.PB_raw_pin[1] = 1'b1;
    tick(8);
    do_reset();

    // 4: 3-cycle glitch on button 2
    bus.PB_raw_pin[2] = 1'b0;
    tick(3);
    bus.PB_raw_pin[2] = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      check4("glitch PB_out", {3'b000, bus.PB_out[2]}, 4'b0000);
      check4("glitch PB_press", bus.PB_press, 4'b0000);
    end

    // 5: switches
    bus.SW_raw_pin = 4'b1010;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      check4("sw SW_out early", bus.SW_out, 4'b0000);
      check4("sw PB_press", bus.PB_press, 4'b0000);
    end
    tick(1);
    check4("sw SW_out", bus.SW_out, 4'b1010);
    check4("sw PB_press", bus.PB_press, 4'b0000);
    bus.SW_raw_pin = 4'b0000;
    tick(8);

    // 6: reset pulse on the 3rd edge of a pending press, button kept held
    bus.PB_raw_pin[3] = 1'b0;
    tick(2);
    check4("midwait PB_out", bus.PB_out, 4'b0000);
    Reset_pin = 1'b1;
    tick(1);
    check4("midwait rst PB_press", bus.PB_press, 4'b0000);
    Reset_pin = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick(1);
      check4("midwait PB_out early", {3'b000, bus.PB_out[3]}, 4'b0000);
      check4("midwait PB_press early", bus.PB_press, 4'b0000);
    end
    tick(1);
    check4("midwait PB_out", {3'b000, bus.PB_out[3]}, 4'b0001);
    check4("midwait PB_press", bus.PB_press, 4'b1000);
    bus.PB_raw_pin[3] = 1'b1;
    tick(8);
    check4("midwait release", {3'b000, bus.PB_out[3]}, TOG ? 4'b0001 : 4'b0000);
    bus.PB_raw_pin[3] = 1'b0;
    tick(6);
    check4("second press PB_out", {3'b000, bus.PB_out[3]}, TOG ? 4'b0000 : 4'b0001);
    check4("second press PB_press", bus.PB_press, 4'b1000);
    bus.PB_raw_pin[3] = 1'b1;
    tick(8);

    // 7: randomized bouncing on all channels with occasional resets
    for (int c = 0; c < 8; c++) hold[c] = 0;
    rv       = {bus.PB_raw_pin, bus.SW_raw_pin};
    rst_left = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 8; c++) begin
        if (hold[c] == 0) begin
          rv[c]   = $urandom_range(0, 1) == 1;
          hold[c] = $urandom_range(1, 9);
        end else begin
          hold[c]--;
        end
      end
      bus.SW_raw_pin = rv[3:0];
      bus.PB_raw_pin = rv[7:4];
      if (rst_left > 0) begin
        rst_left--;
        Reset_pin = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_left  = $urandom_range(0, 2);
        Reset_pin = 1'b1;
      end else begin
        Reset_pin = 1'b0;
      end
      tick(1);
    end
    Reset_pin = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
